bin2bcd_seq: RTL and testbench

- Multi-cycle, parametrised binary-to-BCD converter using the shift-and-add-3 (double dabble) method, processing one input bit per clock.
- Next generation of the team's combinational 8-bit converter. Adds:
  - generic input width and digit count;
  - optional two's-complement signed mode;
  - valid/ready handshakes on both sides.
- Sits between arithmetic datapaths and display or UART formatting logic, where a single shared sequential converter replaces wide combinational add-3 chains.

---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_add3_col.sv | 17 +
 rtl/bin2bcd_seq.sv | 134 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter family:
// digit width, FSM state encoding and the digit-count sizing helper.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Decimal digits needed for the largest magnitude an input of this width can carry.
    function automatic int bcd_digits_needed(input int width, input bit is_signed);
        longint unsigned max_mag;
        int n;
        if (is_signed) begin
            max_mag = 64'd1 << (width - 1);
        end else begin
            max_mag = (64'd1 << width) - 64'd1;
        end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (max_mag >= 64'd10) begin
                max_mag = max_mag / 64'd10;
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3_col.sv
// One BCD digit column of the double-dabble correction: digits of 5 or more
// get 3 added so the following left shift carries correctly into the next digit.
module bcd_add3_col
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] corrected
);

    always_comb begin
        corrected = digit;
        if (digit >= DIGIT_W'(5)) begin
            corrected = digit + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one operand bit per clock,
// with optional two's-complement input and valid/ready on both sides.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BIN_W-1:0]           in_bin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIGIT_W*DIGITS-1:0]  out_bcd,
    output logic                       out_neg,
    output logic                       busy
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 2) begin : g_bad_width
        $error("bin2bcd_seq: BIN_W must be at least 2");
    end
    if (DIGITS < bcd_digits_needed(BIN_W, SIGNED != 0)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for the largest input magnitude");
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and a presented result is held
    // unchanged until it is taken.

    state_t              state_q, state_d;
    logic [BCD_W-1:0]    bcd_q, bcd_fix, bcd_shift, res_q;
    logic [BIN_W-1:0]    op_q, op_load;
    logic [CNT_W-1:0]    cnt_q;
    logic                neg_q, neg_load, res_neg_q, rst_done_q;
    logic                accept, last_shift;

    for (genvar i = 0; i < DIGITS; i++) begin : g_col
        bcd_add3_col u_col (
            .digit     (bcd_q[DIGIT_W*i +: DIGIT_W]),
            .corrected (bcd_fix[DIGIT_W*i +: DIGIT_W])
        );
    end

    assign bcd_shift = (bcd_fix << 1) | BCD_W'(op_q[BIN_W-1]);

    // Negating in BIN_W bits and reading the result unsigned is exact for every
    // negative input, including -2^(BIN_W-1).
    always_comb begin
        op_load  = in_bin;
        neg_load = 1'b0;
        if (SIGNED != 0 && in_bin[BIN_W-1]) begin
            op_load  = -in_bin;
            neg_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        last_shift = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rst_done_q;
                if (in_valid && rst_done_q) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    last_shift = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The result register only changes on the final shift, so out_bcd keeps the
    // last finished value through IDLE and the next conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q     <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            res_q     <= '0;
            res_neg_q <= 1'b0;
        end else if (accept) begin
            bcd_q <= '0;
            op_q  <= op_load;
            cnt_q <= CNT_W'(BIN_W);
            neg_q <= neg_load;
        end else if (state_q == SHIFT) begin
            bcd_q <= bcd_shift;
            op_q  <= op_q << 1;
            cnt_q <= cnt_q - 1'b1;
            if (last_shift) begin
                res_q     <= bcd_shift;
                res_neg_q <= neg_q;
            end
        end
    end

    assign out_bcd = res_q;
    assign out_neg = res_neg_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: unsigned 8-bit, signed 8-bit and
// unsigned 16-bit instances checked against a decimal reference model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_bin;
    logic [2:0]  in_valid, out_ready;
    logic [2:0]  in_ready, out_valid, out_neg, busy;
    logic [11:0] bcd_u, bcd_s;
    logic [19:0] bcd_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_bin(in_bin[7:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_bcd(bcd_u), .out_neg(out_neg[0]), .busy(busy[0])
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_bin(in_bin[7:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_bcd(bcd_s), .out_neg(out_neg[1]), .busy(busy[1])
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_bin(in_bin), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_bcd(bcd_w), .out_neg(out_neg[2]), .busy(busy[2])
    );

    typedef struct {
        int          which;
        logic [15:0] val;
        logic [19:0] exp_bcd;
        logic        exp_neg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] get_bcd(input int w);
        case (w)
            0:       return {8'h00, bcd_u};
            1:       return {8'h00, bcd_s};
            default: return bcd_w;
        endcase
    endfunction

    function automatic int bin_w_of(input int w);
        return (w == 2) ? 16 : 8;
    endfunction

    // Reference: plain decimal digit extraction of the input's magnitude.
    function automatic logic [19:0] ref_bcd(input int w, input logic [15:0] v, output logic neg);
        longint m;
        logic [19:0] r;
        neg = 1'b0;
        if (w == 0) begin
            m = longint'(v[7:0]);
        end else if (w == 1) begin
            m = longint'($signed(v[7:0]));
            if (m < 0) begin
                neg = 1'b1;
                m   = -m;
            end
        end else begin
            m = longint'(v);
        end
        r = '0;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Entered and left at #1 after a rising edge; returns once out_valid is seen.
    task automatic convert(input int w, input logic [15:0] v,
                           output logic [19:0] bcd, output logic neg, output int lat);
        int guard;
        guard = 0;
        while (!in_ready[w] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("in_ready timeout", 32'(in_ready[w]), 32'd1);
        in_bin      = v;
        in_valid[w] = 1'b1;
        @(posedge clk); #1;
        in_valid[w] = 1'b0;
        in_bin      = 16'($urandom);
        lat = 1;
        while (!out_valid[w] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        bcd = get_bcd(w);
        neg = out_neg[w];
    endtask

    vec_t        vecs[14];
    logic [19:0] got_bcd, exp_bcd;
    logic        got_neg, exp_neg;
    logic [15:0] v;
    int          lat;

    initial begin
        vecs[0]  = '{0, 16'd0,     20'h00000, 1'b0};
        vecs[1]  = '{0, 16'd9,     20'h00009, 1'b0};
        vecs[2]  = '{0, 16'd10,    20'h00010, 1'b0};
        vecs[3]  = '{0, 16'd99,    20'h00099, 1'b0};
        vecs[4]  = '{0, 16'd100,   20'h00100, 1'b0};
        vecs[5]  = '{0, 16'd255,   20'h00255, 1'b0};
        vecs[6]  = '{0, 16'hF3,    20'h00243, 1'b0};
        vecs[7]  = '{1, 16'h80,    20'h00128, 1'b1};
        vecs[8]  = '{1, 16'hFF,    20'h00001, 1'b1};
        vecs[9]  = '{1, 16'h7F,    20'h00127, 1'b0};
        vecs[10] = '{1, 16'h00,    20'h00000, 1'b0};
        vecs[11] = '{2, 16'hFFFF,  20'h65535, 1'b0};
        vecs[12] = '{2, 16'd12345, 20'h12345, 1'b0};
        vecs[13] = '{2, 16'd0,     20'h00000, 1'b0};

        rst_n     = 1'b0;
        in_bin    = '0;
        in_valid  = '0;
        out_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            check("reset out_valid", 32'(out_valid[w]), 32'd0);
            check("reset busy", 32'(busy[w]), 32'd0);
            check("reset out_neg", 32'(out_neg[w]), 32'd0);
            check("reset out_bcd", 32'(get_bcd(w)), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int w = 0; w < 3; w++) check("in_ready after reset", 32'(in_ready[w]), 32'd1);

        for (int i = 0; i < 14; i++) begin
            convert(vecs[i].which, vecs[i].val, got_bcd, got_neg, lat);
            check("table bcd", 32'(got_bcd), 32'(vecs[i].exp_bcd));
            check("table neg", 32'(got_neg), 32'(vecs[i].exp_neg));
            check("table latency", 32'(lat), 32'(bin_w_of(vecs[i].which) + 1));
        end

        for (int i = 0; i < 256; i++) begin
            convert(0, 16'(i), got_bcd, got_neg, lat);
            exp_bcd = ref_bcd(0, 16'(i), exp_neg);
            check("exhaustive bcd", 32'(got_bcd), 32'(exp_bcd));
        end

        for (int i = 0; i < 40; i++) begin
            v = 16'($urandom_range(0, 255));
            convert(1, v, got_bcd, got_neg, lat);
            exp_bcd = ref_bcd(1, v, exp_neg);
            check("signed rand bcd", 32'(got_bcd), 32'(exp_bcd));
            check("signed rand neg", 32'(got_neg), 32'(exp_neg));
        end

        for (int i = 0; i < 20; i++) begin
            v = 16'($urandom_range(0, 65535));
            convert(2, v, got_bcd, got_neg, lat);
            exp_bcd = ref_bcd(2, v, exp_neg);
            check("wide rand bcd", 32'(got_bcd), 32'(exp_bcd));
            check("wide rand latency", 32'(lat), 32'd17);
        end

        // Backpressure: result held and new input refused while out_ready is low.
        out_ready[0] = 1'b0;
        convert(0, 16'd200, got_bcd, got_neg, lat);
        check("bp first result", 32'(got_bcd), 32'h200);
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            in_bin      = 16'd7;
            @(posedge clk); #1;
            check("bp out_valid held", 32'(out_valid[0]), 32'd1);
            check("bp out_bcd stable", 32'(bcd_u), 32'h200);
            check("bp in_ready low", 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b0;
        @(posedge clk); #1;
        check("bp out_valid drop", 32'(out_valid[0]), 32'd0);
        check("bp in_ready back", 32'(in_ready[0]), 32'd1);
        check("bp bcd kept", 32'(bcd_u), 32'h200);
        check("bp not busy", 32'(busy[0]), 32'd0);

        // Reset on the 4th shift cycle aborts without presenting anything.
        in_bin      = 16'd99;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("rst busy shift1", 32'(busy[0]), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rst busy shift4", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst abort out_valid", 32'(out_valid[0]), 32'd0);
        check("rst abort busy", 32'(busy[0]), 32'd0);
        check("rst abort bcd", 32'(bcd_u), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst release in_ready", 32'(in_ready[0]), 32'd1);
        check("rst no result", 32'(out_valid[0]), 32'd0);
        convert(0, 16'd42, got_bcd, got_neg, lat);
        check("post reset 42", 32'(got_bcd), 32'h042);
        check("post reset latency", 32'(lat), 32'd9);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
